key_direction_decoder: RTL and testbench
========================================

KEY_DIRECTION_DECODER -- requirements
Module: key_direction_decoder

Interface
REQ-001 Parameter INIT_DIR, default 2'b01 (right), is the heading loaded at reset and on start.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 scan_valid  input  1  one-cycle strobe; scan_code is valid this cycle.
REQ-005 scan_code  input  8  PS/2 set-2 byte from the keyboard receiver.
REQ-006 keyset  input  3  player key set, 1..4; same value that drives the control-mapping block.
REQ-007 left, right, up, down  input  8 each  make codes for this player, from the control-mapping block.
REQ-008 game_enable  input  1  high while the round runs; low freezes heading.
REQ-009 start  input  1  one-cycle pulse; reloads heading to INIT_DIR.
REQ-010 dir  output  2  current heading: 00 up, 01 right, 10 down, 11 left.
REQ-011 turn  output  1  one-cycle pulse when dir changes due to a key.
REQ-012 held  output  4  currently pressed keys {left,down,right,up}, bit 0 = up.

Function
REQ-013 Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); it SHALL advance only on scan_valid.
REQ-014 IDLE: E0 -> EXT; F0 -> BRK; any other byte is a plain make code, stays IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> EXT; any other byte is an extended make code -> IDLE.
REQ-016 BRK: E0 -> EXT (protocol restart, no break applied); other byte is a plain break code -> IDLE.
REQ-017 EXT_BRK: any byte except E0/F0 is an extended break code -> IDLE; E0 -> EXT; F0 -> BRK.
REQ-018 A code matches a key only if its byte equals that key's mapped code AND its extended flag equals (keyset==4); mismatched prefix is ignored.
REQ-019 Matching make code sets the held bit; matching break code clears it; held updates regardless of game_enable.
REQ-020 Matching make code with game_enable=1 requests the new heading; request is rejected if equal to dir or equal to dir XOR 2'b10 (reversal).
REQ-021 Accepted request: dir updates at the clock edge ending the scan_valid cycle; turn is high for exactly the following cycle.
REQ-022 Typematic repeats of the current heading's key SHALL produce no turn pulse.
REQ-023 start has priority over a same-cycle key: dir <= INIT_DIR, turn stays 0, held and FSM unaffected.
REQ-024 keyset values 0, 5-7: no key matches; FSM and held still track bytes (held stays 0).
REQ-025 scan_valid low: FSM, held, dir hold; turn 0.

Reset
REQ-026 resetn low asynchronously forces FSM=IDLE, dir=INIT_DIR, turn=0, held=4'b0000, including mid-prefix sequences.
REQ-027 First byte after reset release is decoded from IDLE.

Structure
REQ-028 Shared package holds direction encodings (UP/RIGHT/DOWN/LEFT), prefix constants 8'hE0 and 8'hF0, and FSM state encoding.
REQ-029 One sub-module, scan_prefix_fsm, SHALL implement REQ-013..017 and emit code_valid, code, is_ext, is_break; matching and heading logic stay in the top.
REQ-030 One instance per player; no cross-player state.

Verification
REQ-031 keyset=1, dir=right, game_enable=1: byte 1D -> dir=up one edge later, turn pulses 1 cycle, held=0001.
REQ-032 keyset=1, dir=right: byte 1C (left) -> dir stays right, turn=0, held bit3=1; then F0,1C -> held bit3=0.
REQ-033 keyset=4: bytes E0,75 -> dir=up; bare 75 -> ignored; E0,F0,75 -> held bit0 cleared, dir unchanged.
REQ-034 keyset=2, dir=up: 2C repeated 5 times -> no turn pulse; then 33 -> dir=right, one turn pulse.
REQ-035 Send E0 then assert resetn=0 then release; send 6B with keyset=4 -> no match, dir=INIT_DIR, held=0000.
REQ-036 start pulse in same cycle as matching make code -> dir=INIT_DIR, turn=0, held bit set.

Source files
------------

// File: rtl/key_direction_decoder_pkg.sv
// Shared encodings for the per-player key-to-heading decoder.
// Heading codes, PS/2 set-2 prefix bytes and the prefix FSM state type.
package key_direction_decoder_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Key set 4 is the arrow cluster, whose codes all carry the E0 prefix.
    localparam logic [2:0] KEYSET_EXT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXT     = 2'b01,
        ST_BRK     = 2'b10,
        ST_EXT_BRK = 2'b11
    } prefix_state_t;

    function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
        return req == (cur ^ 2'b10);
    endfunction

endpackage

// File: rtl/key_direction_decoder_scan_prefix_fsm.sv
// Strips E0/F0 prefixes from the PS/2 byte stream and tags each final code byte.
// Latency: code_valid is combinational in the scan_valid cycle of the final byte.
// Backpressure: none; advances only on scan_valid and never stalls the source.
module scan_prefix_fsm
    import key_direction_decoder_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break
);

    prefix_state_t state, state_nxt;

    always_comb begin
        state_nxt  = state;
        code_valid = 1'b0;
        is_ext     = 1'b0;
        is_break   = 1'b0;
        code       = scan_code;
        if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == PREFIX_EXT)      state_nxt = ST_EXT;
                    else if (scan_code == PREFIX_BRK) state_nxt = ST_BRK;
                    else                              code_valid = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == PREFIX_BRK)      state_nxt = ST_EXT_BRK;
                    else if (scan_code == PREFIX_EXT) state_nxt = ST_EXT;
                    else begin
                        code_valid = 1'b1;
                        is_ext     = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    // A fresh E0 after F0 restarts the sequence; the break is dropped.
                    if (scan_code == PREFIX_EXT) state_nxt = ST_EXT;
                    else begin
                        code_valid = 1'b1;
                        is_break   = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (scan_code == PREFIX_EXT)      state_nxt = ST_EXT;
                    else if (scan_code == PREFIX_BRK) state_nxt = ST_BRK;
                    else begin
                        code_valid = 1'b1;
                        is_ext     = 1'b1;
                        is_break   = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

endmodule

// File: rtl/key_direction_decoder.sv
// Per-player decoder: PS/2 make/break codes -> held-key mask and snake heading.
// Latency: dir/held update on the edge ending the scan_valid cycle; turn pulses the next cycle.
// Backpressure: none; every scan_valid byte is consumed.
module key_direction_decoder
    import key_direction_decoder_pkg::*;
#(
    parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic [2:0] keyset,
    input  logic [7:0] left,
    input  logic [7:0] right,
    input  logic [7:0] up,
    input  logic [7:0] down,
    input  logic       game_enable,
    input  logic       start,
    output logic [1:0] dir,
    output logic       turn,
    output logic [3:0] held
);

    logic       code_valid;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;

    scan_prefix_fsm u_prefix (
        .clock      (clock),
        .resetn     (resetn),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .code       (code),
        .is_ext     (is_ext),
        .is_break   (is_break)
    );

    logic       keyset_ok;
    logic       code_hit;
    logic [3:0] key_match;
    logic       req_vld;
    logic [1:0] req_dir;
    logic       accept;

    assign keyset_ok = (keyset >= 3'd1) && (keyset <= 3'd4);
    assign code_hit  = code_valid && keyset_ok && (is_ext == (keyset == KEYSET_EXT));

    // Bit index equals the heading code, so held and dir share one encoding.
    assign key_match[DIR_UP]    = code_hit && (code == up);
    assign key_match[DIR_RIGHT] = code_hit && (code == right);
    assign key_match[DIR_DOWN]  = code_hit && (code == down);
    assign key_match[DIR_LEFT]  = code_hit && (code == left);

    always_comb begin
        req_dir = DIR_UP;
        if (key_match[DIR_UP])         req_dir = DIR_UP;
        else if (key_match[DIR_RIGHT]) req_dir = DIR_RIGHT;
        else if (key_match[DIR_DOWN])  req_dir = DIR_DOWN;
        else if (key_match[DIR_LEFT])  req_dir = DIR_LEFT;
    end

    assign req_vld = (|key_match) && !is_break && game_enable;
    assign accept  = req_vld && (req_dir != dir) && !is_reversal(req_dir, dir);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dir  <= INIT_DIR;
            turn <= 1'b0;
            held <= 4'b0000;
        end else begin
            held <= is_break ? (held & ~key_match) : (held | key_match);
            turn <= accept && !start;
            if (start)       dir <= INIT_DIR;
            else if (accept) dir <= req_dir;
        end
    end

endmodule

// File: tb/tb_key_direction_decoder.sv
// Directed table of scan bytes with hand-computed heading/turn/held expectations,
// plus hand-written sequences for mid-prefix reset and start-vs-key priority.
module tb_key_direction_decoder;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [2:0] keyset = 3'd1;
    logic [7:0] kl = 8'h00, kr = 8'h00, ku = 8'h00, kd = 8'h00;
    logic       game_enable = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dir;
    logic       turn;
    logic [3:0] held;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    key_direction_decoder #(.INIT_DIR(2'b01)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .keyset      (keyset),
        .left        (kl),
        .right       (kr),
        .up          (ku),
        .down        (kd),
        .game_enable (game_enable),
        .start       (start),
        .dir         (dir),
        .turn        (turn),
        .held        (held)
    );

    typedef struct {
        bit       rst;
        bit [2:0] ks;
        bit       ge;
        bit       st;
        bit [7:0] code;
        bit [1:0] exp_dir;
        bit       exp_turn;
        bit [3:0] exp_held;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit [2:0] ks, input bit ge, input bit st,
                       input bit [7:0] code, input bit [1:0] d, input bit t, input bit [3:0] h);
        vec_t v;
        v.rst = rst; v.ks = ks; v.ge = ge; v.st = st; v.code = code;
        v.exp_dir = d; v.exp_turn = t; v.exp_held = h;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Control-mapping stand-in; keyset 0 deliberately reuses set-1 codes.
    task automatic set_map(input logic [2:0] ks);
        case (ks)
            3'd2:    begin ku = 8'h2C; kr = 8'h33; kd = 8'h34; kl = 8'h2B; end
            3'd3:    begin ku = 8'h43; kr = 8'h4B; kd = 8'h42; kl = 8'h3B; end
            3'd4:    begin ku = 8'h75; kr = 8'h74; kd = 8'h72; kl = 8'h6B; end
            default: begin ku = 8'h1D; kr = 8'h23; kd = 8'h1B; kl = 8'h1C; end
        endcase
        keyset = ks;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input logic st);
        @(negedge clock);
        scan_code  = b;
        scan_valid = 1'b1;
        start      = st;
        @(negedge clock);
        scan_valid = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        // rst ks ge st code  dir   turn held
        add(1, 1, 1, 0, 8'h1D, 2'b00, 1, 4'b0001);   // up from right
        add(0, 1, 1, 0, 8'hF0, 2'b00, 0, 4'b0001);
        add(0, 1, 1, 0, 8'h1D, 2'b00, 0, 4'b0000);   // break up
        add(0, 1, 1, 0, 8'h1B, 2'b00, 0, 4'b0100);   // reversal rejected
        add(0, 1, 1, 0, 8'h1C, 2'b11, 1, 4'b1100);   // left
        add(0, 1, 1, 0, 8'hF0, 2'b11, 0, 4'b1100);
        add(0, 1, 1, 0, 8'h1B, 2'b11, 0, 4'b1000);
        add(0, 1, 1, 0, 8'h23, 2'b11, 0, 4'b1010);   // reversal rejected
        add(0, 1, 1, 0, 8'h1C, 2'b11, 0, 4'b1010);   // typematic
        add(1, 1, 1, 0, 8'h1C, 2'b01, 0, 4'b1000);   // left while right
        add(0, 1, 1, 0, 8'hF0, 2'b01, 0, 4'b1000);
        add(0, 1, 1, 0, 8'h1C, 2'b01, 0, 4'b0000);
        add(0, 1, 0, 0, 8'h1B, 2'b01, 0, 4'b0100);   // game disabled: held only
        add(0, 1, 1, 0, 8'h1B, 2'b10, 1, 4'b0100);
        add(1, 4, 1, 0, 8'hE0, 2'b01, 0, 4'b0000);
        add(0, 4, 1, 0, 8'h75, 2'b00, 1, 4'b0001);   // extended up
        add(0, 4, 1, 0, 8'h75, 2'b00, 0, 4'b0001);   // bare 75 ignored
        add(0, 4, 1, 0, 8'hE0, 2'b00, 0, 4'b0001);
        add(0, 4, 1, 0, 8'hF0, 2'b00, 0, 4'b0001);
        add(0, 4, 1, 0, 8'h75, 2'b00, 0, 4'b0000);   // extended break
        add(1, 0, 1, 0, 8'h1D, 2'b01, 0, 4'b0000);   // keyset 0 never matches
        add(0, 1, 1, 0, 8'hE0, 2'b01, 0, 4'b0000);
        add(0, 1, 1, 0, 8'h1D, 2'b01, 0, 4'b0000);   // extended on set 1 ignored
        add(1, 2, 1, 0, 8'h2C, 2'b00, 1, 4'b0001);
        for (int i = 0; i < 5; i++)
            add(0, 2, 1, 0, 8'h2C, 2'b00, 0, 4'b0001);
        add(0, 2, 1, 0, 8'h33, 2'b01, 1, 4'b0011);
        add(1, 3, 1, 0, 8'h4B, 2'b01, 0, 4'b0010);   // same heading, no turn
        add(0, 3, 1, 0, 8'h42, 2'b10, 1, 4'b0110);

        set_map(3'd1);
        repeat (2) @(negedge clock);
        check("reset_dir", -1, {2'b00, dir}, 4'b0001);
        check("reset_turn", -1, {3'b000, turn}, 4'b0000);
        check("reset_held", -1, held, 4'b0000);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            set_map(vecs[i].ks);
            game_enable = vecs[i].ge;
            send(vecs[i].code, vecs[i].st);
            check("dir", i, {2'b00, dir}, {2'b00, vecs[i].exp_dir});
            check("turn", i, {3'b000, turn}, {3'b000, vecs[i].exp_turn});
            check("held", i, held, vecs[i].exp_held);
            if (vecs[i].exp_turn) begin
                @(negedge clock);
                check("turn_one_cycle", i, {3'b000, turn}, 4'b0000);
            end
        end

        // Reset asserted mid-prefix, then an extended-looking byte without its prefix.
        do_reset();
        set_map(3'd4);
        game_enable = 1'b1;
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("async_rst_dir", 100, {2'b00, dir}, 4'b0001);
        check("async_rst_held", 100, held, 4'b0000);
        @(negedge clock);
        resetn = 1'b1;
        send(8'h6B, 1'b0);
        check("post_rst_dir", 101, {2'b00, dir}, 4'b0001);
        check("post_rst_turn", 101, {3'b000, turn}, 4'b0000);
        check("post_rst_held", 101, held, 4'b0000);

        // start wins over a same-cycle accepted make code.
        do_reset();
        set_map(3'd1);
        send(8'h1D, 1'b1);
        check("start_key_dir", 102, {2'b00, dir}, 4'b0001);
        check("start_key_turn", 102, {3'b000, turn}, 4'b0000);
        check("start_key_held", 102, held, 4'b0001);
        send(8'h1B, 1'b0);
        check("turn_after_start", 103, {2'b00, dir}, 4'b0010);
        send(8'h12, 1'b1);
        check("start_reload_dir", 104, {2'b00, dir}, 4'b0001);
        check("start_reload_turn", 104, {3'b000, turn}, 4'b0000);
        check("start_reload_held", 104, held, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
